// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Holds the exception code constants, reset defaults and the stage payload layout.
package cpu_pkg;

   localparam logic [4:0]  EXC_NONE   = 5'd0;
   localparam logic [31:0] REQ_PC_DEF = 32'h0000_4180;
   localparam int          TNEW_W_DEF = 2;

   // Standard payload carried between stages; the instantiator packs it into in_payload.
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] rd2;
      logic [31:0] imm32;
      logic [4:0]  rt;
      logic [4:0]  rs;
      logic [21:0] ctrl;
   } stage_payload_t;

   localparam int STAGE_PAYLOAD_W = $bits(stage_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones, never wraps.
// Latency 1 cycle; clear has priority over inc, no backpressure.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, exception clear and bubble counting.
// Latency 1 cycle; en=0 holds every output, priority reset > req > flush > hold > load.
module pipe_stage_reg
   import cpu_pkg::*;
#(
   parameter int          DATA_W   = 128,
   parameter int          TNEW_W   = TNEW_W_DEF,
   parameter bit          DEC_TNEW = 1'b1,
   parameter logic [31:0] REQ_PC   = REQ_PC_DEF,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic              req,
   input  logic              in_valid,
   input  logic [31:0]       in_pc,
   input  logic              in_bd,
   input  logic [4:0]        in_exccode,
   input  logic [4:0]        in_exc_local,
   input  logic              in_regwrite,
   input  logic [4:0]        in_a3,
   input  logic [TNEW_W-1:0] in_tnew,
   input  logic [DATA_W-1:0] in_payload,
   output logic              out_valid,
   output logic [31:0]       out_pc,
   output logic              out_bd,
   output logic [4:0]        out_exccode,
   output logic              out_regwrite,
   output logic [4:0]        out_a3,
   output logic [TNEW_W-1:0] out_tnew,
   output logic [DATA_W-1:0] out_payload,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic [4:0]        exc_merged;
   logic [TNEW_W-1:0] tnew_next;
   logic              bubble_inc;

   // Earliest stage's exception wins over one raised here.
   assign exc_merged = (in_exccode != EXC_NONE) ? in_exccode : in_exc_local;

   always_comb begin
      tnew_next = '0;
      if (in_valid) begin
         if (DEC_TNEW) begin
            tnew_next = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
         end else begin
            tnew_next = in_tnew;
         end
      end
   end

   assign bubble_inc = req || flush || (en && !in_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_bd       <= 1'b0;
         out_exccode  <= EXC_NONE;
         out_regwrite <= 1'b0;
         out_a3       <= '0;
         out_tnew     <= '0;
         out_payload  <= '0;
      end else if (req) begin
         out_valid    <= 1'b0;
         out_pc       <= REQ_PC;
         out_bd       <= 1'b0;
         out_exccode  <= EXC_NONE;
         out_regwrite <= 1'b0;
         out_a3       <= '0;
         out_tnew     <= '0;
         out_payload  <= '0;
      end else if (flush) begin
         // PC/BD survive the bubble so EPC stays right if an interrupt lands on it.
         out_valid    <= 1'b0;
         out_pc       <= in_pc;
         out_bd       <= in_bd;
         out_exccode  <= EXC_NONE;
         out_regwrite <= 1'b0;
         out_a3       <= '0;
         out_tnew     <= '0;
         out_payload  <= '0;
      end else if (en) begin
         out_valid    <= in_valid;
         out_pc       <= in_pc;
         out_bd       <= in_bd;
         out_exccode  <= exc_merged;
         out_regwrite <= in_regwrite & in_valid;
         out_a3       <= in_valid ? in_a3 : 5'd0;
         out_tnew     <= tnew_next;
         out_payload  <= in_payload;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (bubble_inc),
      .cnt   (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a rule-level reference model.
// dut0: DEC_TNEW=1, CNT_W=16; dut1: DEC_TNEW=0, CNT_W=4.
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         reset, en, flush, req;
   logic         in_valid, in_bd, in_regwrite;
   logic [31:0]  in_pc;
   logic [4:0]   in_exccode, in_exc_local, in_a3;
   logic [1:0]   in_tnew;
   logic [127:0] in_payload;

   logic         o0_valid, o0_bd, o0_regwrite;
   logic [31:0]  o0_pc;
   logic [4:0]   o0_exccode, o0_a3;
   logic [1:0]   o0_tnew;
   logic [127:0] o0_payload;
   logic [15:0]  o0_cnt;

   logic         o1_valid, o1_bd, o1_regwrite;
   logic [31:0]  o1_pc;
   logic [4:0]   o1_exccode, o1_a3;
   logic [1:0]   o1_tnew;
   logic [127:0] o1_payload;
   logic [3:0]   o1_cnt;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic         m_valid, m_bd, m_regwrite;
   logic [31:0]  m_pc;
   logic [4:0]   m_exccode, m_a3;
   int           m_tnew0, m_tnew1, m_cnt0, m_cnt1;
   logic [127:0] m_payload;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(128), .TNEW_W(2), .DEC_TNEW(1'b1), .REQ_PC(32'h0000_4180), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
      .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exccode(in_exccode),
      .in_exc_local(in_exc_local), .in_regwrite(in_regwrite), .in_a3(in_a3),
      .in_tnew(in_tnew), .in_payload(in_payload),
      .out_valid(o0_valid), .out_pc(o0_pc), .out_bd(o0_bd), .out_exccode(o0_exccode),
      .out_regwrite(o0_regwrite), .out_a3(o0_a3), .out_tnew(o0_tnew),
      .out_payload(o0_payload), .bubble_cnt(o0_cnt));

   pipe_stage_reg #(.DATA_W(128), .TNEW_W(2), .DEC_TNEW(1'b0), .REQ_PC(32'h0000_4180), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
      .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exccode(in_exccode),
      .in_exc_local(in_exc_local), .in_regwrite(in_regwrite), .in_a3(in_a3),
      .in_tnew(in_tnew), .in_payload(in_payload),
      .out_valid(o1_valid), .out_pc(o1_pc), .out_bd(o1_bd), .out_exccode(o1_exccode),
      .out_regwrite(o1_regwrite), .out_a3(o1_a3), .out_tnew(o1_tnew),
      .out_payload(o1_payload), .bubble_cnt(o1_cnt));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bump(input int c, input int max);
      return (c < max) ? c + 1 : c;
   endfunction

   task automatic clear_model();
      m_valid = 0; m_pc = 0; m_bd = 0; m_exccode = 0; m_regwrite = 0;
      m_a3 = 0; m_tnew0 = 0; m_tnew1 = 0; m_payload = '0;
   endtask

   task automatic update_model();
      if (reset) begin
         clear_model();
         m_cnt0 = 0; m_cnt1 = 0;
      end else if (req) begin
         clear_model();
         m_pc = 32'h0000_4180;
         m_cnt0 = bump(m_cnt0, 65535); m_cnt1 = bump(m_cnt1, 15);
      end else if (flush) begin
         clear_model();
         m_pc = in_pc; m_bd = in_bd;
         m_cnt0 = bump(m_cnt0, 65535); m_cnt1 = bump(m_cnt1, 15);
      end else if (en) begin
         m_valid    = in_valid;
         m_pc       = in_pc;
         m_bd       = in_bd;
         m_payload  = in_payload;
         m_exccode  = (in_exccode != 0) ? in_exccode : in_exc_local;
         m_regwrite = in_regwrite && in_valid;
         m_a3       = in_valid ? in_a3 : 5'd0;
         m_tnew0    = !in_valid ? 0 : (in_tnew > 0 ? int'(in_tnew) - 1 : 0);
         m_tnew1    = in_valid ? int'(in_tnew) : 0;
         if (!in_valid) begin
            m_cnt0 = bump(m_cnt0, 65535); m_cnt1 = bump(m_cnt1, 15);
         end
      end
   endtask

   task automatic compare_all();
      check("valid",    128'(o0_valid),    128'(m_valid));
      check("pc",       128'(o0_pc),       128'(m_pc));
      check("bd",       128'(o0_bd),       128'(m_bd));
      check("exccode",  128'(o0_exccode),  128'(m_exccode));
      check("regwrite", 128'(o0_regwrite), 128'(m_regwrite));
      check("a3",       128'(o0_a3),       128'(m_a3));
      check("tnew_dec", 128'(o0_tnew),     128'(m_tnew0));
      check("payload",  o0_payload,        m_payload);
      check("cnt16",    128'(o0_cnt),      128'(m_cnt0));
      check("pc_d1",    128'(o1_pc),       128'(m_pc));
      check("a3_d1",    128'(o1_a3),       128'(m_a3));
      check("tnew_pass",128'(o1_tnew),     128'(m_tnew1));
      check("cnt4",     128'(o1_cnt),      128'(m_cnt1));
   endtask

   task automatic cycle();
      @(posedge clk);
      update_model();
      #1;
      compare_all();
   endtask

   task automatic rand_inputs();
      in_valid     = 1'($urandom);
      in_pc        = $urandom;
      in_bd        = 1'($urandom);
      in_exccode   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      in_exc_local = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      in_regwrite  = 1'($urandom);
      in_a3        = 5'($urandom);
      in_tnew      = 2'($urandom);
      in_payload   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic load(input logic [31:0] pc, input logic v, input logic [1:0] t);
      rand_inputs();
      reset = 0; req = 0; flush = 0; en = 1;
      in_pc = pc; in_valid = v; in_tnew = t;
   endtask

   initial begin
      reset = 1; req = 0; flush = 0; en = 0;
      rand_inputs();
      m_cnt0 = 0; m_cnt1 = 0;
      clear_model();
      #1;
      // reset with random inputs
      repeat (2) begin
         rand_inputs(); req = 1'($urandom); flush = 1'($urandom); en = 1'($urandom);
         cycle();
      end
      // first load
      load(32'h3000, 1, 2); in_a3 = 5; in_regwrite = 1; cycle();
      load(32'h3010, 1, 0); cycle();
      load(32'h3014, 1, 2); cycle();
      // stall then flush
      load(32'h3004, 1, 3); cycle();
      repeat (3) begin
         rand_inputs(); en = 0; cycle();
      end
      load(32'h3008, 1, 1); flush = 1; in_bd = 1; cycle();
      // exception merge
      load(32'h3020, 1, 1); in_exccode = 0; in_exc_local = 5'd12; cycle();
      load(32'h3024, 1, 1); in_exccode = 5'd4; in_exc_local = 5'd12; cycle();
      // req beats flush and stall
      load(32'h300C, 1, 2); req = 1; flush = 1; en = 0; cycle();
      // bubble counter saturation
      repeat (20) begin
         load($urandom, 0, 2'($urandom)); cycle();
      end
      load(32'h3030, 1, 2); cycle();
      // random traffic
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         reset = ($urandom_range(0, 99) == 0);
         req   = ($urandom_range(0, 15) == 0);
         flush = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 3) != 0);
         cycle();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
